led_chase_decoder: RTL and testbench



---
 rtl/led_chase_pkg.sv | 18 +
 rtl/led_pair_classify.sv | 35 +++
 rtl/led_chase_decoder.sv | 157 +++++++++++++++
 tb/tb_led_chase_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_chase_pkg.sv
// Shared definitions for the LED two-dot chase decoder.
//   LED_WIDTH : default LED bus width (power of two, >= 4)
//   POS_W     : width of a dot position index for LED_WIDTH
//   ERR_CNT_W : width of the saturating bad-sample counter
//   state_t   : decoder FSM states
package led_chase_pkg;

    localparam int LED_WIDTH = 8;
    localparam int POS_W     = $clog2(LED_WIDTH);
    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/led_pair_classify.sv
// Combinational classifier for one LED bus sample.
// Ports:
//   i_led   : observed LED bus
//   o_legal : 1 when exactly two cyclically adjacent bits are set
//   o_pos   : lower index of the lit pair; the wrap pair {WIDTH-1, 0}
//             reports WIDTH-1. Zero when the sample is illegal.
module led_pair_classify #(
    parameter int WIDTH = 8,
    parameter int PW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_led,
    output logic             o_legal,
    output logic [PW-1:0]    o_pos
);

    logic [WIDTH-1:0] w_mask;

    // Compare against every legal two-dot mask; at most one can match,
    // so a whole-bus equality check also rejects extra or missing dots.
    always_comb begin
        o_legal = 1'b0;
        o_pos   = '0;
        w_mask  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_mask                  = '0;
            w_mask[i]               = 1'b1;
            w_mask[(i + 1) % WIDTH] = 1'b1;
            if (i_led == w_mask) begin
                o_legal = 1'b1;
                o_pos   = PW'(i);
            end
        end
    end

endmodule

// File: rtl/led_chase_decoder.sv
// Receive-side decoder for the two-dot LED chaser. Samples the LED bus on
// strobe, locks onto the rotation, reports dot position and direction,
// counts completed laps and flags bad samples while locked.
// Ports:
//   i_clk      : clock, rising edge
//   i_rs       : synchronous active-low reset
//   i_en       : sample strobe; i_led_in is evaluated only when high
//   i_led_in   : observed LED bus
//   o_pos      : lower index of the lit pair
//   o_dir      : 0 = position increments, 1 = position decrements
//   o_locked   : high while locked onto the rotation
//   o_err      : one-cycle pulse per bad sample while locked
//   o_err_cnt  : bad samples since reset, saturating
//   o_lap_cnt  : completed laps, wrapping
//   o_state    : current FSM state (debug visibility)
module led_chase_decoder
    import led_chase_pkg::*;
#(
    parameter int WIDTH     = LED_WIDTH,
    parameter int LAP_W     = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rs,
    input  logic                    i_en,
    input  logic [WIDTH-1:0]        i_led_in,
    output logic [$clog2(WIDTH)-1:0] o_pos,
    output logic                    o_dir,
    output logic                    o_locked,
    output logic                    o_err,
    output logic [ERR_CNT_W-1:0]    o_err_cnt,
    output logic [LAP_W-1:0]        o_lap_cnt,
    output logic [1:0]              o_state
);

    localparam int PW     = $clog2(WIDTH);
    localparam int MISS_W = $clog2(ERR_LIMIT + 1);

    state_t               r_state, w_state_nxt;
    logic [PW-1:0]        r_pos, w_pos_nxt;
    logic                 r_dir, w_dir_nxt;
    logic                 r_locked;
    logic                 r_err, w_err_nxt;
    logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt_nxt;
    logic [LAP_W-1:0]     r_lap_cnt, w_lap_nxt;
    logic [MISS_W-1:0]    r_miss, w_miss_nxt;

    logic                 w_legal;
    logic [PW-1:0]        w_pos_c;
    logic [PW-1:0]        w_pos_inc;
    logic [PW-1:0]        w_pos_dec;
    logic [PW-1:0]        w_exp;

    led_pair_classify #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_classify (
        .i_led   (i_led_in),
        .o_legal (w_legal),
        .o_pos   (w_pos_c)
    );

    // WIDTH is a power of two, so PW-bit arithmetic wraps modulo WIDTH.
    assign w_pos_inc = r_pos + 1'b1;
    assign w_pos_dec = r_pos - 1'b1;
    assign w_exp     = r_dir ? w_pos_dec : w_pos_inc;

    always_comb begin
        w_state_nxt   = r_state;
        w_pos_nxt     = r_pos;
        w_dir_nxt     = r_dir;
        w_miss_nxt    = r_miss;
        w_err_nxt     = 1'b0;
        w_err_cnt_nxt = r_err_cnt;
        w_lap_nxt     = r_lap_cnt;
        if (i_en) begin
            case (r_state)
                HUNT: begin
                    if (w_legal) begin
                        w_pos_nxt   = w_pos_c;
                        w_state_nxt = ACQ;
                    end
                end
                ACQ: begin
                    if (!w_legal) begin
                        w_state_nxt = HUNT;
                    end else if (w_pos_c == w_pos_inc) begin
                        w_dir_nxt   = 1'b0;
                        w_pos_nxt   = w_pos_c;
                        w_state_nxt = LOCKED;
                        // The step that achieves lock counts as a good step,
                        // including for lap completion.
                        if (w_pos_c == '0) w_lap_nxt = r_lap_cnt + 1'b1;
                    end else if (w_pos_c == w_pos_dec) begin
                        w_dir_nxt   = 1'b1;
                        w_pos_nxt   = w_pos_c;
                        w_state_nxt = LOCKED;
                        if (w_pos_c == '1) w_lap_nxt = r_lap_cnt + 1'b1;
                    end else begin
                        // Stalled (same position) or jumped: track and retry.
                        w_pos_nxt = w_pos_c;
                    end
                end
                LOCKED: begin
                    if (w_legal && (w_pos_c == w_exp)) begin
                        w_pos_nxt  = w_exp;
                        w_miss_nxt = '0;
                        if ((!r_dir && (w_exp == '0)) || (r_dir && (w_exp == '1)))
                            w_lap_nxt = r_lap_cnt + 1'b1;
                    end else begin
                        // Position is never re-synced while locked.
                        w_err_nxt = 1'b1;
                        if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + 1'b1;
                        if (r_miss == MISS_W'(ERR_LIMIT - 1)) begin
                            w_miss_nxt  = '0;
                            w_state_nxt = HUNT;
                        end else begin
                            w_miss_nxt = r_miss + 1'b1;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rs) begin
            r_state   <= HUNT;
            r_pos     <= '0;
            r_dir     <= 1'b0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_lap_cnt <= '0;
            r_miss    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pos     <= w_pos_nxt;
            r_dir     <= w_dir_nxt;
            r_locked  <= (w_state_nxt == LOCKED);
            r_err     <= w_err_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_lap_cnt <= w_lap_nxt;
            r_miss    <= w_miss_nxt;
        end
    end

    assign o_pos     = r_pos;
    assign o_dir     = r_dir;
    assign o_locked  = r_locked;
    assign o_err     = r_err;
    assign o_err_cnt = r_err_cnt;
    assign o_lap_cnt = r_lap_cnt;
    assign o_state   = r_state;

endmodule

// File: tb/tb_led_chase_decoder.sv
// Bench for led_chase_decoder: behavioural model + per-cycle compare,
// plus directed vectors with literal expectations.
module tb_led_chase_decoder;

    localparam int W = 8;

    logic       clk;
    logic       rs;
    logic       en;
    logic [7:0] led;
    logic [2:0] o_pos;
    logic       o_dir;
    logic       o_locked;
    logic       o_err;
    logic [7:0] o_err_cnt;
    logic [7:0] o_lap_cnt;
    logic [1:0] o_state;

    int n_checks = 0;
    int n_err    = 0;

    led_chase_decoder #(
        .WIDTH     (8),
        .LAP_W     (8),
        .ERR_LIMIT (3)
    ) dut (
        .i_clk     (clk),
        .i_rs      (rs),
        .i_en      (en),
        .i_led_in  (led),
        .o_pos     (o_pos),
        .o_dir     (o_dir),
        .o_locked  (o_locked),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt),
        .o_lap_cnt (o_lap_cnt),
        .o_state   (o_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 hunting, 1 seen one legal sample, 2 locked
    int m_mode, m_pos, m_dir, m_miss, m_ec, m_lap, m_err;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int  mode, pos, dir, miss, ec, lap, err, cnt, pc, ex;
        bit  legal;
        mode = m_mode; pos = m_pos; dir = m_dir; miss = m_miss;
        ec = m_ec; lap = m_lap; err = 0;
        if (!rs) begin
            mode = 0; pos = 0; dir = 0; miss = 0; ec = 0; lap = 0;
        end else if (en) begin
            cnt = 0; legal = 1'b0; pc = 0;
            for (int i = 0; i < W; i++) if (led[i]) cnt++;
            for (int i = 0; i < W; i++)
                if (cnt == 2 && led[i] && led[(i + 1) % W]) begin
                    legal = 1'b1;
                    pc = i;
                end
            if (mode == 0) begin
                if (legal) begin pos = pc; mode = 1; end
            end else if (mode == 1) begin
                if (!legal) mode = 0;
                else if (pc == (pos + 1) % W) begin
                    dir = 0; pos = pc; mode = 2;
                    if (pc == 0) lap = (lap + 1) % 256;
                end else if (pc == (pos + W - 1) % W) begin
                    dir = 1; pos = pc; mode = 2;
                    if (pc == W - 1) lap = (lap + 1) % 256;
                end else pos = pc;
            end else begin
                ex = (dir == 0) ? (pos + 1) % W : (pos + W - 1) % W;
                if (legal && pc == ex) begin
                    pos = ex; miss = 0;
                    if ((dir == 0 && ex == 0) || (dir == 1 && ex == W - 1))
                        lap = (lap + 1) % 256;
                end else begin
                    err = 1;
                    if (ec < 255) ec++;
                    miss++;
                    if (miss == 3) begin mode = 0; miss = 0; end
                end
            end
        end
        m_mode <= mode; m_pos <= pos; m_dir <= dir; m_miss <= miss;
        m_ec <= ec; m_lap <= lap; m_err <= err;
        if (!rs) m_valid <= 1'b1;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pos",     32'(o_pos),     32'(m_pos));
            check("model_dir",     32'(o_dir),     32'(m_dir));
            check("model_locked",  32'(o_locked),  32'(m_mode == 2));
            check("model_err",     32'(o_err),     32'(m_err));
            check("model_err_cnt", 32'(o_err_cnt), 32'(m_ec));
            check("model_lap_cnt", 32'(o_lap_cnt), 32'(m_lap));
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic e, input logic [7:0] l);
        rs  = r;
        en  = e;
        led = l;
        @(negedge clk);
    endtask

    initial begin
        rs = 1'b0; en = 1'b0; led = 8'h00;
        drive(0, 0, 8'h00);
        drive(0, 0, 8'h00);
        check("rst_locked",  32'(o_locked),  0);
        check("rst_pos",     32'(o_pos),     0);
        check("rst_err_cnt", 32'(o_err_cnt), 0);
        check("rst_lap_cnt", 32'(o_lap_cnt), 0);

        // Forward chase
        drive(1, 1, 8'h03);
        check("acq_state", 32'(o_state), 1);
        check("acq_locked", 32'(o_locked), 0);
        drive(1, 1, 8'h06);
        check("lock_locked", 32'(o_locked), 1);
        check("lock_pos", 32'(o_pos), 1);
        check("lock_dir", 32'(o_dir), 0);
        drive(1, 1, 8'h0C);
        check("fwd_pos2", 32'(o_pos), 2);
        drive(1, 1, 8'h18);
        drive(1, 1, 8'h30);
        drive(1, 1, 8'h60);
        drive(1, 1, 8'hC0);
        check("wrap_pos6", 32'(o_pos), 6);
        drive(1, 1, 8'h81);
        check("wrap_pos7", 32'(o_pos), 7);
        check("wrap_lap0", 32'(o_lap_cnt), 0);
        drive(1, 1, 8'h03);
        check("wrap_pos0", 32'(o_pos), 0);
        check("wrap_lap1", 32'(o_lap_cnt), 1);
        check("fwd_no_err", 32'(o_err_cnt), 0);

        // Recovery: misses cleared by a good sample
        drive(1, 1, 8'h06);
        drive(1, 1, 8'h0C);
        drive(1, 1, 8'h05);
        check("rec_err_pulse", 32'(o_err), 1);
        drive(1, 1, 8'h18);
        check("rec_err_clear", 32'(o_err), 0);
        drive(1, 1, 8'h00);
        drive(1, 1, 8'hFF);
        check("rec_still_locked", 32'(o_locked), 1);
        check("rec_pos_hold", 32'(o_pos), 3);
        check("rec_err_cnt", 32'(o_err_cnt), 3);
        drive(1, 1, 8'h30);

        // Loss of lock after three consecutive bad samples
        drive(1, 1, 8'h05);
        drive(1, 1, 8'h00);
        check("loss_locked_2", 32'(o_locked), 1);
        drive(1, 1, 8'hFF);
        check("loss_locked_3", 32'(o_locked), 0);
        check("loss_err_cnt", 32'(o_err_cnt), 6);
        check("loss_state", 32'(o_state), 0);
        drive(1, 1, 8'h11);
        check("hunt_no_err", 32'(o_err), 0);
        check("hunt_err_cnt", 32'(o_err_cnt), 6);

        // Reverse rotation
        drive(1, 1, 8'h03);
        drive(1, 1, 8'h81);
        check("rev_locked", 32'(o_locked), 1);
        check("rev_dir", 32'(o_dir), 1);
        check("rev_pos", 32'(o_pos), 7);
        check("rev_lap", 32'(o_lap_cnt), 2);
        drive(1, 1, 8'hC0);
        drive(1, 1, 8'h60);
        check("rev_pos5", 32'(o_pos), 5);

        // en gating
        drive(1, 0, 8'h0F);
        drive(1, 0, 8'h03);
        drive(1, 0, 8'hAA);
        check("gate_pos", 32'(o_pos), 5);
        check("gate_locked", 32'(o_locked), 1);
        drive(1, 1, 8'h00);
        check("gate_bad_err", 32'(o_err), 1);
        drive(1, 0, 8'hFF);
        check("gate_err_low", 32'(o_err), 0);
        check("gate_err_cnt", 32'(o_err_cnt), 7);

        // Reset mid-lock (with en=1 on the same edge)
        drive(0, 1, 8'h0C);
        check("rst_mid_locked", 32'(o_locked), 0);
        check("rst_mid_pos", 32'(o_pos), 0);
        check("rst_mid_lap", 32'(o_lap_cnt), 0);
        check("rst_mid_err_cnt", 32'(o_err_cnt), 0);

        // ACQ corners: stall, jump, lock onto wrap
        drive(1, 1, 8'h0C);
        drive(1, 1, 8'h0C);
        check("stall_state", 32'(o_state), 1);
        check("stall_pos", 32'(o_pos), 2);
        drive(1, 1, 8'h81);
        check("jump_state", 32'(o_state), 1);
        check("jump_pos", 32'(o_pos), 7);
        drive(1, 1, 8'h03);
        check("acqwrap_locked", 32'(o_locked), 1);
        check("acqwrap_lap", 32'(o_lap_cnt), 1);
        drive(1, 1, 8'h00);
        drive(1, 1, 8'h00);
        drive(1, 1, 8'h00);
        drive(1, 1, 8'h06);
        drive(1, 1, 8'h11);
        check("acq_bad_state", 32'(o_state), 0);
        check("acq_bad_err_cnt", 32'(o_err_cnt), 3);

        // Saturation of the bad-sample counter
        for (int k = 0; k < 90; k++) begin
            drive(1, 1, 8'h03);
            drive(1, 1, 8'h06);
            drive(1, 1, 8'h00);
            drive(1, 1, 8'h00);
            drive(1, 1, 8'h00);
        end
        check("sat_err_cnt", 32'(o_err_cnt), 255);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
